// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
//
// Purpose : Shared definitions for the thermometer expander and its
//           surroundings. Holds the word geometry, the expander state
//           encoding, and the count-to-mask function.
//
// Contents:
//   N_BITS   - thermometer width and serial beats per count (11)
//   CW       - count width (4). 2**CW must exceed N_BITS.
//   SAT_MAX  - N_BITS as a CW-bit value, the saturation ceiling
//   LAST_IDX - index of the final serial beat of a word
//   state_t  - expander state {IDLE, SEND}
//   thermo() - N_BITS-wide mask with the low 'sat' bits set
// -----------------------------------------------------------------------------
package npu_pkg;

   localparam int N_BITS = 11;
   localparam int CW     = 4;

   localparam logic [CW-1:0] SAT_MAX  = CW'(N_BITS);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_BITS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Built bit by bit instead of as (1 << sat) - 1. That way sat == N_BITS
   // yields all ones without an N_BITS+1 wide intermediate.
   function automatic logic [N_BITS-1:0] thermo(input logic [CW-1:0] sat);
      logic [N_BITS-1:0] mask;
      mask = '0;
      for (int i = 0; i < N_BITS; i++) begin
         mask[i] = (i < int'(sat));
      end
      return mask;
   endfunction

endpackage : npu_pkg

// File: rtl/thermo_expander_11_count_saturator.sv
// -----------------------------------------------------------------------------
// count_saturator
//
// Purpose : Clamps an incoming population count to the thermometer width.
//           It also flags counts that had to be clamped. Purely combinational.
//
// Ports:
//   cnt_in - raw count, CW bits (0..2**CW-1)
//   sat    - min(cnt_in, N_BITS)
//   over   - high when cnt_in > N_BITS
// -----------------------------------------------------------------------------
module count_saturator
   import npu_pkg::*;
(
   input  logic [CW-1:0] cnt_in,
   output logic [CW-1:0] sat,
   output logic          over
);

   assign over = (cnt_in > SAT_MAX);
   assign sat  = over ? SAT_MAX : cnt_in;

endmodule : count_saturator

// File: rtl/thermo_expander_11.sv
// -----------------------------------------------------------------------------
// thermo_expander_11
//
// Purpose : Inverse of the 11-to-4 compression adder. It accepts a 4-bit
//           population count and expands it into an 11-bit thermometer word
//           with the ones in the low positions. The word is presented in
//           parallel and is also streamed LSB first, one bit per handshake
//           beat. A count on the last beat of a word is taken in the same
//           cycle, so the stream has no bubble.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   cnt_valid  - count offered upstream
//   cnt_ready  - block can take a count this cycle
//   cnt_in     - count value (CW bits)
//   bit_valid  - serial bit offered downstream
//   bit_ready  - downstream takes the serial bit
//   bit_out    - current thermometer bit
//   bit_last   - marks the final beat (idx == N_BITS-1) of a word
//   therm_out  - parallel thermometer of the word in flight, 0 when idle
//   sat_err    - one-cycle pulse after accepting a count above N_BITS
// -----------------------------------------------------------------------------
module thermo_expander_11
   import npu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cnt_valid,
   output logic              cnt_ready,
   input  logic [CW-1:0]     cnt_in,
   output logic              bit_valid,
   input  logic              bit_ready,
   output logic              bit_out,
   output logic              bit_last,
   output logic [N_BITS-1:0] therm_out,
   output logic              sat_err
);

   state_t              state;
   logic [CW-1:0]       idx;
   logic [N_BITS-1:0]   therm_q;
   logic                sat_err_q;

   logic [CW-1:0]       sat;
   logic                over;
   logic                last_beat;
   logic                accept;

   count_saturator u_sat (
      .cnt_in (cnt_in),
      .sat    (sat),
      .over   (over)
   );

   // ---------------------------------------------------------------------------
   // Output decode. bit_out and bit_last depend only on registered state and
   // idx, so downstream never sees a path from bit_ready to them.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default at the top of the block, so no
      // path through it can leave a value unassigned and infer a latch.
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      bit_out   = 1'b0;
      if (state == SEND) begin
         bit_valid = 1'b1;
         bit_last  = (idx == LAST_IDX);
         bit_out   = therm_q[idx];
      end
   end

   // The only input-to-output combinational path is bit_ready -> cnt_ready.
   // This path lets a new count load on the closing beat of the current word.
   assign last_beat = bit_last & bit_ready;
   assign cnt_ready = (state == IDLE) | last_beat;
   assign accept    = cnt_valid & cnt_ready;

   assign therm_out = therm_q;
   assign sat_err   = sat_err_q;

   // ---------------------------------------------------------------------------
   // FSM, beat index and mask register. idx is cleared explicitly on every
   // load and at the end of a word. It never counts past LAST_IDX.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers then update together from values sampled before the edge.
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         therm_q   <= '0;
         sat_err_q <= 1'b0;
      end else begin
         sat_err_q <= 1'b0;
         if (accept) begin
            // Covers both a load from IDLE and a back-to-back load on the
            // last beat of a word.
            state     <= SEND;
            idx       <= '0;
            therm_q   <= thermo(sat);
            sat_err_q <= over;
         end else if ((state == SEND) && bit_ready) begin
            if (idx == LAST_IDX) begin
               state   <= IDLE;
               idx     <= '0;
               therm_q <= '0;
            end else begin
               idx <= idx + CW'(1);
            end
         end
      end
   end

endmodule : thermo_expander_11

// File: tb/tb_thermo_expander_11.sv
// -----------------------------------------------------------------------------
// tb_thermo_expander_11
//
// Self-checking bench for thermo_expander_11. Each cycle, inputs are driven on
// the falling edge and outputs are sampled 1 ns later. Outputs are compared
// against a word-level reference model: a count in flight, a beat position, and
// the rule "bit i of a word is 1 when i < min(count, 11)".
// -----------------------------------------------------------------------------
module tb_thermo_expander_11;

   logic        clk;
   logic        rst;
   logic        cnt_valid;
   logic        cnt_ready;
   logic [3:0]  cnt_in;
   logic        bit_valid;
   logic        bit_ready;
   logic        bit_out;
   logic        bit_last;
   logic [10:0] therm_out;
   logic        sat_err;

   thermo_expander_11 dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_valid (cnt_valid),
      .cnt_ready (cnt_ready),
      .cnt_in    (cnt_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_out   (bit_out),
      .bit_last  (bit_last),
      .therm_out (therm_out),
      .sat_err   (sat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   bit in_word  = 1'b0;
   int pos      = 0;
   int sat_n    = 0;
   bit sat_pend = 1'b0;

   // Observations collected per scenario.
   logic        obs_q[$];
   int          hs          = 0;
   int          last_seen   = 0;
   int          sat_seen    = 0;
   int          valid_cyc   = 0;
   logic [10:0] therm_seen  = '0;
   bit          therm_taken = 1'b0;
   bit          prev_stall  = 1'b0;
   logic        prev_bit    = 1'b0;
   logic        prev_last   = 1'b0;

   typedef struct {
      logic [3:0]  cnt;
      logic [10:0] therm;
      int          ones;
      int          sat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_obs();
      obs_q.delete();
      hs          = 0;
      last_seen   = 0;
      sat_seen    = 0;
      valid_cyc   = 0;
      therm_taken = 1'b0;
      therm_seen  = '0;
   endtask

   function automatic int popcount(input logic q[$]);
      int n = 0;
      foreach (q[i]) if (q[i] === 1'b1) n++;
      return n;
   endfunction

   // One clock cycle: drive, sample, compare with the model, advance the model.
   task automatic step(input logic v, input logic [3:0] c, input logic r);
      int exp_therm;
      bit exp_ready;
      bit beat;
      bit acc;
      @(negedge clk);
      cnt_valid = v;
      cnt_in    = c;
      bit_ready = r;
      #1;
      exp_therm = in_word ? ((1 << sat_n) - 1) : 0;
      exp_ready = !in_word || (pos == 10 && r);
      check("bit_valid", bit_valid, in_word);
      check("bit_out",   bit_out,   in_word && (pos < sat_n));
      check("bit_last",  bit_last,  in_word && (pos == 10));
      check("cnt_ready", cnt_ready, exp_ready);
      check("therm_out", therm_out, exp_therm);
      check("sat_err",   sat_err,   sat_pend);
      if (prev_stall) begin
         check("stall_bit_out",  bit_out,  prev_bit);
         check("stall_bit_last", bit_last, prev_last);
      end
      if (bit_valid === 1'b1) begin
         valid_cyc++;
         if (!therm_taken) begin
            therm_seen  = therm_out;
            therm_taken = 1'b1;
         end
         if (r) begin
            obs_q.push_back(bit_out);
            hs++;
            if (bit_last === 1'b1) last_seen++;
         end
      end
      if (sat_err === 1'b1) sat_seen++;
      prev_stall = (bit_valid === 1'b1) && !r;
      prev_bit   = bit_out;
      prev_last  = bit_last;
      // Model advance for the coming rising edge.
      sat_pend = 1'b0;
      beat     = in_word && r;
      acc      = v && exp_ready;
      if (beat) begin
         if (pos == 10) in_word = 1'b0;
         else           pos++;
      end
      if (acc) begin
         in_word  = 1'b1;
         pos      = 0;
         sat_n    = (c > 11) ? 11 : int'(c);
         sat_pend = (c > 11);
      end
   endtask

   task automatic run_word(input string name, input logic [3:0] c,
                           input logic [10:0] exp_therm, input int exp_ones, input int exp_sat);
      logic [10:0] packed_bits;
      clear_obs();
      step(1'b1, c, 1'b1);
      repeat (11) step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b1);
      packed_bits = '0;
      foreach (obs_q[i]) if (i < 11) packed_bits[i] = obs_q[i];
      check({name, "_beats"},   obs_q.size(), 11);
      check({name, "_therm"},   therm_seen, exp_therm);
      check({name, "_pattern"}, packed_bits, exp_therm);
      check({name, "_popcnt"},  popcount(obs_q), exp_ones);
      check({name, "_sat_err"}, sat_seen, exp_sat);
      check({name, "_last"},    last_seen, 1);
   endtask

   initial begin
      logic [21:0] b2b_bits;
      int          cyc;

      vecs[0] = '{cnt: 4'd5,  therm: 11'h01F, ones: 5,  sat: 0};
      vecs[1] = '{cnt: 4'd0,  therm: 11'h000, ones: 0,  sat: 0};
      vecs[2] = '{cnt: 4'd11, therm: 11'h7FF, ones: 11, sat: 0};
      vecs[3] = '{cnt: 4'd14, therm: 11'h7FF, ones: 11, sat: 1};
      vecs[4] = '{cnt: 4'd12, therm: 11'h7FF, ones: 11, sat: 1};
      vecs[5] = '{cnt: 4'd15, therm: 11'h7FF, ones: 11, sat: 1};
      vecs[6] = '{cnt: 4'd1,  therm: 11'h001, ones: 1,  sat: 0};
      vecs[7] = '{cnt: 4'd10, therm: 11'h3FF, ones: 10, sat: 0};

      cnt_valid = 1'b0;
      cnt_in    = '0;
      bit_ready = 1'b0;
      rst       = 1'b0;
      #2 rst    = 1'b1;
      #1;
      check("rst_therm",     therm_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_bit_out",   bit_out,   0);
      check("rst_bit_last",  bit_last,  0);
      check("rst_sat_err",   sat_err,   0);
      check("rst_cnt_ready", cnt_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table-driven single words with bit_ready held high.
      foreach (vecs[i]) begin
         run_word($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].therm, vecs[i].ones, vecs[i].sat);
      end

      // Back-to-back: 3 then 7, cnt_valid held high across the first word.
      clear_obs();
      step(1'b1, 4'd3, 1'b1);
      repeat (11) step(1'b1, 4'd7, 1'b1);
      repeat (11) step(1'b0, 4'd0, 1'b1);
      check("b2b_valid_run", valid_cyc, 22);
      step(1'b0, 4'd0, 1'b1);
      b2b_bits = '0;
      foreach (obs_q[i]) if (i < 22) b2b_bits[i] = obs_q[i];
      check("b2b_beats",   obs_q.size(), 22);
      check("b2b_pattern", b2b_bits, 22'h3F807);
      check("b2b_last",    last_seen, 2);

      // Backpressure: count 6 with pseudo-random bit_ready.
      clear_obs();
      step(1'b1, 4'd6, 1'b1);
      cyc = 0;
      while (hs < 11 && cyc < 300) begin
         step(1'b0, 4'd0, 1'($urandom_range(0, 1)));
         cyc++;
      end
      check("bp_handshakes", hs, 11);
      check("bp_popcnt",     popcount(obs_q), 6);
      check("bp_last",       last_seen, 1);
      step(1'b0, 4'd0, 1'b1);
      check("bp_idle_after", bit_valid, 0);

      // Reset in the middle of a word of 9, at beat 4.
      clear_obs();
      step(1'b1, 4'd9, 1'b1);
      repeat (4) step(1'b0, 4'd0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_therm",     therm_out, 0);
      check("mid_rst_bit_valid", bit_valid, 0);
      check("mid_rst_bit_out",   bit_out,   0);
      check("mid_rst_bit_last",  bit_last,  0);
      check("mid_rst_sat_err",   sat_err,   0);
      check("mid_rst_cnt_ready", cnt_ready, 1);
      @(negedge clk);
      check("mid_rst_hold_last", bit_last, 0);
      rst        = 1'b0;
      in_word    = 1'b0;
      pos        = 0;
      sat_pend   = 1'b0;
      prev_stall = 1'b0;
      check("mid_rst_no_last", last_seen, 0);
      #1;
      check("post_rst_cnt_ready", cnt_ready, 1);
      run_word("post_rst", 4'd2, 11'h003, 2, 0);

      // Randomised traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_thermo_expander_11
